// File: rtl/camera_capture_scheduler_pkg.sv
// Shared types and defaults for the camera capture scheduler: FSM encoding,
// image/crop geometry defaults and the derived crop pixel count.
package camera_capture_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VS  = 3'd1,
        WAIT_SOF = 3'd2,
        CAPTURE  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DEF_IMG_W     = 640;
    localparam int DEF_IMG_H     = 480;
    localparam int DEF_CROP_X0   = 208;
    localparam int DEF_CROP_Y0   = 128;
    localparam int DEF_CROP_SIZE = 224;
    localparam int DEF_ADDR_W    = 16;

    // Coordinates are compared one bit wider than the reader indices so
    // CROP_X0 + CROP_SIZE never wraps.
    localparam int COORD_W = 11;

    function automatic int crop_pixels(input int size);
        return size * size;
    endfunction

    localparam int CROP_PIXELS = crop_pixels(DEF_CROP_SIZE);

endpackage

// File: rtl/camera_capture_scheduler_if.sv
// Control, pixel-stream and buffer-write signals of the capture scheduler.
// slave = the scheduler itself, master = camera reader / buffer consumer side.
interface camera_capture_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic              i_start;
    logic              i_continuous;
    logic              i_vsync;
    logic              i_pixelValid;
    logic [15:0]       i_pixel;
    logic [9:0]        i_xIndex;
    logic [9:0]        i_yIndex;
    logic              o_wrEn;
    logic              o_wrBank;
    logic [ADDR_W-1:0] o_wrAddr;
    logic [15:0]       o_wrData;
    logic              o_frameDone;
    logic              o_doneBank;
    logic              i_release;
    logic              i_releaseBank;
    logic              o_busy;
    logic              o_error;

    modport master (
        output i_start, i_continuous, i_vsync, i_pixelValid, i_pixel,
               i_xIndex, i_yIndex, i_release, i_releaseBank,
        input  o_wrEn, o_wrBank, o_wrAddr, o_wrData, o_frameDone,
               o_doneBank, o_busy, o_error
    );

    modport slave (
        input  i_start, i_continuous, i_vsync, i_pixelValid, i_pixel,
               i_xIndex, i_yIndex, i_release, i_releaseBank,
        output o_wrEn, o_wrBank, o_wrAddr, o_wrData, o_frameDone,
               o_doneBank, o_busy, o_error
    );
endinterface

// File: rtl/camera_capture_scheduler_crop_window_filter.sv
// Registered crop-window decode and row-major write address counter.
// A pixel accepted on one cycle is written on the next.
module camera_capture_scheduler_crop_window_filter
    import camera_capture_scheduler_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int CROP_X0   = DEF_CROP_X0,
    parameter int CROP_Y0   = DEF_CROP_Y0,
    parameter int CROP_SIZE = DEF_CROP_SIZE,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              i_pclk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic              i_pixelValid,
    input  logic [15:0]       i_pixel,
    input  logic [9:0]        i_xIndex,
    input  logic [9:0]        i_yIndex,
    output logic              o_wrEn,
    output logic [ADDR_W-1:0] o_wrAddr,
    output logic [15:0]       o_wrData,
    output logic              o_lastWrite
);

    localparam logic [COORD_W-1:0] X_LO  = COORD_W'(CROP_X0);
    localparam logic [COORD_W-1:0] X_HI  = COORD_W'(CROP_X0 + CROP_SIZE);
    localparam logic [COORD_W-1:0] Y_LO  = COORD_W'(CROP_Y0);
    localparam logic [COORD_W-1:0] Y_HI  = COORD_W'(CROP_Y0 + CROP_SIZE);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(crop_pixels(CROP_SIZE) - 1);

    logic [COORD_W-1:0] x_col;
    logic [COORD_W-1:0] y_row;
    logic               in_window;
    logic               accept;

    logic               wr_en_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [15:0]        wr_data_reg;
    logic [ADDR_W-1:0]  count_reg;
    logic [ADDR_W-1:0]  count_next;

    // The reader has already bumped xIndex on the valid cycle; index 0
    // underflows to all-ones and lands outside any window.
    assign x_col = {1'b0, i_xIndex} - COORD_W'(1);
    assign y_row = {1'b0, i_yIndex};

    assign in_window = (x_col >= X_LO) && (x_col < X_HI) && (x_col < X_MAX) &&
                       (y_row >= Y_LO) && (y_row < Y_HI) && (y_row < Y_MAX);
    assign accept     = i_enable && i_pixelValid && in_window;
    assign count_next = count_reg + ADDR_W'(1);

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            count_reg   <= '0;
        end else if (i_clear) begin
            wr_en_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            wr_en_reg <= accept;
            if (accept) begin
                wr_addr_reg <= count_reg;
                wr_data_reg <= i_pixel;
                count_reg   <= count_next;
            end
        end
    end

    assign o_wrEn      = wr_en_reg;
    assign o_wrAddr    = wr_addr_reg;
    assign o_wrData    = wr_data_reg;
    assign o_lastWrite = wr_en_reg && (wr_addr_reg == LAST_ADDR);

endmodule

// File: rtl/camera_capture_scheduler.sv
// Frame capture sequencer: arms on request, aligns to a frame boundary, crops
// a square window into one of two banks and hands full banks to the consumer.
module camera_capture_scheduler
    import camera_capture_scheduler_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int CROP_X0   = DEF_CROP_X0,
    parameter int CROP_Y0   = DEF_CROP_Y0,
    parameter int CROP_SIZE = DEF_CROP_SIZE,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                       i_pclk,
    input  logic                       i_reset,
    camera_capture_scheduler_if.slave  bus
);

    state_t      state_reg;
    state_t      state_next;
    logic        wr_bank_reg;
    logic        wr_bank_next;
    logic [1:0]  full_reg;
    logic [1:0]  full_next;
    logic        pend_reg;
    logic        pend_next;

    logic [1:0]  rel_hit;
    logic [1:0]  set_hit;
    logic        cap_enable;
    logic        cap_clear;
    logic        frame_done;
    logic        short_frame;
    logic        last_write;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    camera_capture_scheduler_crop_window_filter #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .CROP_X0   (CROP_X0),
        .CROP_Y0   (CROP_Y0),
        .CROP_SIZE (CROP_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_filter (
        .i_pclk       (i_pclk),
        .i_reset      (i_reset),
        .i_enable     (cap_enable),
        .i_clear      (cap_clear),
        .i_pixelValid (bus.i_pixelValid),
        .i_pixel      (bus.i_pixel),
        .i_xIndex     (bus.i_xIndex),
        .i_yIndex     (bus.i_yIndex),
        .o_wrEn       (wr_en),
        .o_wrAddr     (wr_addr),
        .o_wrData     (wr_data),
        .o_lastWrite  (last_write)
    );

    // Release and completion never hit the same bank, so each flag can
    // apply both independently.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign rel_hit[gi]   = bus.i_release && (bus.i_releaseBank == 1'(gi));
        assign set_hit[gi]   = (state_reg == DONE) && (wr_bank_reg == 1'(gi));
        assign full_next[gi] = (full_reg[gi] & ~rel_hit[gi]) | set_hit[gi];
    end

    always_comb begin
        state_next   = state_reg;
        wr_bank_next = wr_bank_reg;
        pend_next    = pend_reg;
        cap_enable   = 1'b0;
        cap_clear    = 1'b0;
        frame_done   = 1'b0;
        short_frame  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_start || pend_reg || bus.i_continuous) begin
                    if (!full_reg[wr_bank_reg]) begin
                        state_next = WAIT_VS;
                        pend_next  = 1'b0;
                    end else begin
                        pend_next = pend_reg | bus.i_start;
                    end
                end
            end
            WAIT_VS: begin
                if (bus.i_vsync) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                cap_clear = 1'b1;
                if (!bus.i_vsync) state_next = CAPTURE;
            end
            CAPTURE: begin
                // Pixels seen alongside vsync belong to a frame being abandoned.
                cap_enable = !bus.i_vsync;
                if (last_write) begin
                    state_next = DONE;
                end else if (bus.i_vsync) begin
                    short_frame = 1'b1;
                    state_next  = WAIT_SOF;
                end
            end
            DONE: begin
                frame_done   = 1'b1;
                wr_bank_next = ~wr_bank_reg;
                if (bus.i_continuous && !full_next[~wr_bank_reg]) state_next = WAIT_VS;
                else                                              state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            wr_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
            pend_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_bank_reg <= wr_bank_next;
            full_reg    <= full_next;
            pend_reg    <= pend_next;
        end
    end

    assign bus.o_wrEn      = wr_en;
    assign bus.o_wrBank    = wr_bank_reg;
    assign bus.o_wrAddr    = wr_addr;
    assign bus.o_wrData    = wr_data;
    assign bus.o_frameDone = frame_done;
    assign bus.o_doneBank  = frame_done & wr_bank_reg;
    assign bus.o_busy      = (state_reg != IDLE);
    assign bus.o_error     = short_frame;

endmodule

// File: tb/tb_camera_capture_scheduler.sv
// Directed bench for camera_capture_scheduler on a scaled 20x16 image with an
// 8x8 crop at (6,4); pixel value is (y<<8)|x so every write is predictable.
module tb_camera_capture_scheduler;

    localparam int IMG_W     = 20;
    localparam int IMG_H     = 16;
    localparam int CROP_X0   = 6;
    localparam int CROP_Y0   = 4;
    localparam int CROP_SIZE = 8;
    localparam int ADDR_W    = 6;
    localparam int NPIX      = CROP_SIZE * CROP_SIZE;
    localparam int LAST_ROW  = CROP_Y0 + CROP_SIZE - 1;
    localparam int REL_COL   = CROP_X0 + CROP_SIZE + 1;
    localparam int VB        = 4;
    localparam int BP        = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    int wr_idx    = 0;
    int wr_total  = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int done_bank = 0;
    int first_addr, first_data, last_addr, last_data;
    int w0;
    bit hit;

    camera_capture_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    camera_capture_scheduler #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .CROP_X0   (CROP_X0),
        .CROP_Y0   (CROP_Y0),
        .CROP_SIZE (CROP_SIZE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .i_pclk  (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int idx);
        int r;
        int c;
        r = CROP_Y0 + idx / CROP_SIZE;
        c = CROP_X0 + idx % CROP_SIZE;
        return 16'((r << 8) | c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_pixelValid  = 1'b0;
        bus.i_start       = 1'b0;
        bus.i_release     = 1'b0;
        bus.i_releaseBank = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic release_bank(input bit b);
        bus.i_release     = 1'b1;
        bus.i_releaseBank = b;
        tick();
        bus.i_release     = 1'b0;
        bus.i_releaseBank = 1'b0;
    endtask

    // One camera frame: vsync blanking, back porch, then `lines` rows of
    // IMG_W pixels with a one-cycle gap per row.
    task automatic drive_frame(input int lines, input int start_line, input bit rel_at_done,
                               input int rst_addr, output bit rst_hit);
        rst_hit = 1'b0;
        idle_inputs();
        bus.i_vsync = 1'b1;
        repeat (VB) tick();
        bus.i_vsync = 1'b0;
        repeat (BP) tick();
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if (rst_addr >= 0 && bus.o_wrEn && int'(bus.o_wrAddr) == rst_addr) begin
                    idle_inputs();
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    rst_hit = 1'b1;
                    return;
                end
                bus.i_pixelValid  = 1'b1;
                bus.i_xIndex      = 10'(x + 1);
                bus.i_yIndex      = 10'(y);
                bus.i_pixel       = 16'((y << 8) | x);
                bus.i_start       = (y == start_line) && (x == 0);
                bus.i_release     = rel_at_done && (y == LAST_ROW) && (x == REL_COL);
                bus.i_releaseBank = 1'b0;
                tick();
            end
            idle_inputs();
            tick();
        end
        idle_inputs();
    endtask

    // Write scoreboard: every write must carry the next row-major crop address
    // and the pixel value that address maps to.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_idx = 0;
            end else begin
                if (bus.o_wrEn) begin
                    if (wr_idx == 0) begin
                        first_addr = int'(bus.o_wrAddr);
                        first_data = int'(bus.o_wrData);
                    end
                    last_addr = int'(bus.o_wrAddr);
                    last_data = int'(bus.o_wrData);
                    chk("wr_addr", 32'(bus.o_wrAddr), 32'(wr_idx));
                    chk("wr_data", 32'(bus.o_wrData), 32'(exp_pix(wr_idx)));
                    wr_idx++;
                    wr_total++;
                end
                if (bus.o_frameDone) begin
                    chk("frame_len", 32'(wr_idx), 32'(NPIX));
                    done_cnt++;
                    done_bank = int'(bus.o_doneBank);
                    $display("frame done: bank %0d writes %0d", done_bank, wr_idx);
                    wr_idx = 0;
                end
                if (bus.o_error) begin
                    err_cnt++;
                    $display("short frame: error after %0d writes", wr_idx);
                    wr_idx = 0;
                end
            end
        end
    end

    initial begin
        bus.i_start       = 1'b0;
        bus.i_continuous  = 1'b0;
        bus.i_vsync       = 1'b0;
        bus.i_pixelValid  = 1'b0;
        bus.i_pixel       = '0;
        bus.i_xIndex      = '0;
        bus.i_yIndex      = '0;
        bus.i_release     = 1'b0;
        bus.i_releaseBank = 1'b0;
        repeat (3) tick();

        chk("rst_wrEn",      32'(bus.o_wrEn), 0);
        chk("rst_wrBank",    32'(bus.o_wrBank), 0);
        chk("rst_wrAddr",    32'(bus.o_wrAddr), 0);
        chk("rst_wrData",    32'(bus.o_wrData), 0);
        chk("rst_frameDone", 32'(bus.o_frameDone), 0);
        chk("rst_doneBank",  32'(bus.o_doneBank), 0);
        chk("rst_busy",      32'(bus.o_busy), 0);
        chk("rst_error",     32'(bus.o_error), 0);
        chk("rst_full",      32'(dut.full_reg), 0);
        rst = 1'b0;
        tick();

        // Single shot into bank 0
        pulse_start();
        chk("ss_armed_busy", 32'(bus.o_busy), 1);
        w0 = wr_total;
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("ss_writes",     32'(wr_total - w0), NPIX);
        chk("ss_first_addr", 32'(first_addr), 0);
        chk("ss_first_data", 32'(first_data), 32'h0406);
        chk("ss_last_addr",  32'(last_addr), NPIX - 1);
        chk("ss_last_data",  32'(last_data), 32'h0B0D);
        chk("ss_done_cnt",   32'(done_cnt), 1);
        chk("ss_done_bank",  32'(done_bank), 0);
        chk("ss_busy",       32'(bus.o_busy), 0);
        chk("ss_wr_bank",    32'(bus.o_wrBank), 1);
        release_bank(1'b0);

        // Arm in the middle of a frame: nothing until the next frame boundary
        w0 = wr_total;
        drive_frame(IMG_H, 6, 1'b0, -1, hit);
        chk("mf_no_writes",  32'(wr_total - w0), 0);
        chk("mf_busy",       32'(bus.o_busy), 1);
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("mf_writes",     32'(wr_total - w0), NPIX);
        chk("mf_done_cnt",   32'(done_cnt), 2);
        chk("mf_done_bank",  32'(done_bank), 1);
        release_bank(1'b1);

        // Short frame, then a full retry into the same bank
        pulse_start();
        w0 = wr_total;
        drive_frame(8, -1, 1'b0, -1, hit);
        chk("sf_partial",    32'(wr_total - w0), 32);
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("sf_err_cnt",    32'(err_cnt), 1);
        chk("sf_done_cnt",   32'(done_cnt), 3);
        chk("sf_done_bank",  32'(done_bank), 0);
        chk("sf_busy",       32'(bus.o_busy), 0);
        release_bank(1'b0);

        // Reset in the middle of capture
        pulse_start();
        drive_frame(IMG_H, -1, 1'b0, 20, hit);
        chk("mr_reset_hit",  32'(hit), 1);
        chk("mr_wrEn",       32'(bus.o_wrEn), 0);
        chk("mr_wrBank",     32'(bus.o_wrBank), 0);
        chk("mr_wrAddr",     32'(bus.o_wrAddr), 0);
        chk("mr_wrData",     32'(bus.o_wrData), 0);
        chk("mr_busy",       32'(bus.o_busy), 0);
        chk("mr_full",       32'(dut.full_reg), 0);
        repeat (40) tick();
        chk("mr_no_done",    32'(done_cnt), 3);
        chk("mr_no_error",   32'(err_cnt), 1);

        // Continuous ping-pong without releases
        bus.i_continuous = 1'b1;
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("pp_a_done_cnt", 32'(done_cnt), 4);
        chk("pp_a_bank",     32'(done_bank), 0);
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("pp_b_done_cnt", 32'(done_cnt), 5);
        chk("pp_b_bank",     32'(done_bank), 1);
        chk("pp_idle",       32'(bus.o_busy), 0);
        w0 = wr_total;
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("pp_blocked",    32'(wr_total - w0), 0);
        chk("pp_blk_busy",   32'(bus.o_busy), 0);
        release_bank(1'b0);
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("pp_d_done_cnt", 32'(done_cnt), 6);
        chk("pp_d_bank",     32'(done_bank), 0);
        chk("pp_d_idle",     32'(bus.o_busy), 0);

        // Release of bank 0 on the same cycle bank 1 completes
        release_bank(1'b1);
        drive_frame(IMG_H, -1, 1'b1, -1, hit);
        chk("sim_done_cnt",  32'(done_cnt), 7);
        chk("sim_bank",      32'(done_bank), 1);
        chk("sim_full",      32'(dut.full_reg), 32'h2);
        chk("sim_busy",      32'(bus.o_busy), 1);
        bus.i_continuous = 1'b0;
        drive_frame(IMG_H, -1, 1'b0, -1, hit);
        chk("sim_f_done",    32'(done_cnt), 8);
        chk("sim_f_bank",    32'(done_bank), 0);
        chk("sim_f_busy",    32'(bus.o_busy), 0);
        chk("end_err_cnt",   32'(err_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
